// File: rtl/cqpic_defs.sv
// Shared constants for the CQPIC file-register access path: operation
// encodings, the INDF address, the default SFR window and sequencer states.
package cqpic_defs;

    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;
    localparam logic [1:0] OP_RMW   = 2'b11;

    localparam logic [6:0] INDF_ADDR   = 7'h00;
    localparam logic [6:0] SFR_TOP_DEF = 7'h0B;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_CAPT   = 3'd2,
        ST_RESP   = 3'd3,
        ST_MODIFY = 3'd4,
        ST_WRITE  = 3'd5
    } seq_state_t;

endpackage

// File: rtl/file_access_seq_addr_gen.sv
// Combinational file-register address decode: direct or INDF-indirect
// effective address, SFR/GPR split, null (INDF-via-INDF) detection and
// the dataram address with optional bank mirroring.
module file_addr_gen
    import cqpic_defs::*;
#(
    parameter logic [6:0] SFR_TOP    = SFR_TOP_DEF,
    parameter bit         MIRROR_GPR = 1'b1
) (
    input  logic [6:0] f_addr,
    input  logic [1:0] rp,
    input  logic       irp,
    input  logic [7:0] fsr,
    output logic [6:0] low7,
    output logic       is_null,
    output logic       sfr_hit,
    output logic       gpr_hit,
    output logic [8:0] ram_addr
);

    logic [8:0] eff;

    // Decode the operand into effective address and target class.
    always_comb begin
        eff      = (f_addr == INDF_ADDR) ? {irp, fsr} : {rp, f_addr};
        low7     = eff[6:0];
        is_null  = (f_addr == INDF_ADDR) && (fsr[6:0] == 7'd0);
        sfr_hit  = (low7 <= SFR_TOP) && !is_null;
        gpr_hit  = !sfr_hit && !is_null;
        ram_addr = MIRROR_GPR ? {2'b00, low7} : eff;
    end

endmodule

// File: rtl/file_access_seq.sv
// File-register access sequencer in front of the CQPIC dataram. Runs read,
// write and read-modify-write cycles, accounting for the one-cycle
// registered RAM output, and steers SFR traffic to the SFR block.
module file_access_seq
    import cqpic_defs::*;
#(
    parameter logic [6:0] SFR_TOP    = SFR_TOP_DEF,
    parameter bit         MIRROR_GPR = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req,
    input  logic [1:0] op,
    input  logic [6:0] f_addr,
    input  logic [1:0] rp,
    input  logic       irp,
    input  logic [7:0] fsr,
    input  logic [7:0] wdata,
    input  logic [7:0] alu_result,
    input  logic       alu_valid,
    input  logic [7:0] sfr_rdata,
    input  logic [7:0] ram_dataout,
    output logic [8:0] ram_addr,
    output logic       ram_read,
    output logic       ram_write,
    output logic [7:0] ram_datain,
    output logic       sfr_sel,
    output logic       sfr_write,
    output logic [6:0] sfr_addr,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       busy,
    output logic       done
);

    seq_state_t state, state_n;
    logic [1:0] op_q;
    logic       null_q;
    logic       gpr_q;
    logic       accept;

    logic [6:0] dec_low7;
    logic       dec_null;
    logic       dec_sfr;
    logic       dec_gpr;
    logic [8:0] dec_ram_addr;

    file_addr_gen #(
        .SFR_TOP    (SFR_TOP),
        .MIRROR_GPR (MIRROR_GPR)
    ) u_addr_gen (
        .f_addr   (f_addr),
        .rp       (rp),
        .irp      (irp),
        .fsr      (fsr),
        .low7     (dec_low7),
        .is_null  (dec_null),
        .sfr_hit  (dec_sfr),
        .gpr_hit  (dec_gpr),
        .ram_addr (dec_ram_addr)
    );

    assign accept = (state == ST_IDLE) && req && (op != OP_NONE);

    // State register plus the operand/data registers loaded along the way.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            op_q       <= OP_NONE;
            null_q     <= 1'b0;
            gpr_q      <= 1'b0;
            sfr_sel    <= 1'b0;
            sfr_addr   <= 7'd0;
            ram_addr   <= 9'd0;
            ram_datain <= 8'd0;
            rd_data    <= 8'd0;
        end else begin
            state <= state_n;
            if (accept) begin
                op_q     <= op;
                null_q   <= dec_null;
                gpr_q    <= dec_gpr;
                sfr_sel  <= dec_sfr;
                sfr_addr <= dec_low7;
                ram_addr <= dec_ram_addr;
                if (op == OP_WRITE) begin
                    ram_datain <= wdata;
                end
            end
            if (state == ST_CAPT) begin
                rd_data <= null_q ? 8'd0 : (sfr_sel ? sfr_rdata : ram_dataout);
            end
            if ((state == ST_MODIFY) && alu_valid) begin
                ram_datain <= alu_result;
            end
        end
    end

    // Next-state and strobe decode; strobes are squashed while reset is low
    // so an interrupted operation can never write.
    always_comb begin
        state_n   = state;
        ram_read  = 1'b0;
        ram_write = 1'b0;
        sfr_write = 1'b0;
        rd_valid  = 1'b0;
        done      = 1'b0;
        busy      = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_n = (op == OP_WRITE) ? ST_WRITE : ST_READ;
                end
            end
            ST_READ: begin
                ram_read = gpr_q;
                state_n  = ST_CAPT;
            end
            ST_CAPT: begin
                state_n = ST_RESP;
            end
            ST_RESP: begin
                rd_valid = 1'b1;
                if (op_q == OP_RMW) begin
                    state_n = ST_MODIFY;
                end else begin
                    done    = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            ST_MODIFY: begin
                if (alu_valid) begin
                    state_n = ST_WRITE;
                end
            end
            ST_WRITE: begin
                done      = 1'b1;
                ram_write = gpr_q;
                sfr_write = sfr_sel;
                state_n   = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
        if (!reset_n) begin
            state_n   = ST_IDLE;
            ram_read  = 1'b0;
            ram_write = 1'b0;
            sfr_write = 1'b0;
            rd_valid  = 1'b0;
            done      = 1'b0;
            busy      = 1'b0;
        end
    end

endmodule
